// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared geometry constants and sign-extension helpers for the bullet pool
package game_pkg;

   localparam int N_PBULLET     = 4;
   localparam int FIRE_COOLDOWN = 8;
   localparam int CD_W          = $clog2(FIRE_COOLDOWN);
   localparam int HIT_W         = 3;

   // Geometry is kept at 12-bit signed so sums of an 11-bit coordinate and
   // an offset never wrap before they are compared.
   localparam logic signed [11:0] BULLET_X       = 12'sd4;
   localparam logic signed [11:0] BULLET_Y       = 12'sd4;
   localparam logic signed [11:0] BULLET_STEP_X  = 12'sd8;
   localparam logic signed [11:0] PLAYER_X       = 12'sd16;
   localparam logic signed [11:0] PLAYER_Y       = 12'sd32;
   localparam logic signed [11:0] SQUAT_PLAYER_Y = 12'sd16;
   localparam logic signed [11:0] MAP_X          = 12'sd320;

   function automatic logic signed [11:0] sx11(input logic [10:0] v);
      return {v[10], v};
   endfunction

   function automatic logic signed [11:0] sx10(input logic [9:0] v);
      return {{2{v[9]}}, v};
   endfunction

endpackage

// File: rtl/player_bullet_slot.sv
// rtl/player_bullet_slot.sv - one bullet slot: spawn, move, collide with enemy, despawn at map edge
module player_bullet_slot
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_spawn,
   input  logic [10:0] i_spawn_x,
   input  logic [9:0]  i_spawn_y,
   input  logic [10:0] i_x_enemy,
   input  logic [9:0]  i_y_enemy,
   input  logic        i_enemy_q,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   output logic        o_ise,
   output logic        o_collide
);

   logic [10:0]       r_x;
   logic [9:0]        r_y;
   logic              r_ise;

   logic signed [11:0] w_xn;
   logic signed [11:0] w_h;
   logic signed [11:0] w_y;
   logic signed [11:0] w_ye;
   logic               w_in_x;
   logic               w_in_y;
   logic               w_collide;
   logic               w_exit;

   // Next position and enemy/boundary tests, all evaluated on the stepped x
   always_comb begin
      w_xn      = sx11(r_x) + BULLET_STEP_X;
      w_h       = i_enemy_q ? SQUAT_PLAYER_Y : PLAYER_Y;
      w_y       = sx10(r_y);
      w_ye      = sx10(i_y_enemy);
      w_in_x    = (w_xn + BULLET_X) > (sx11(i_x_enemy) - PLAYER_X);
      w_in_y    = !(((w_y - BULLET_Y) > (w_ye + w_h)) ||
                    ((w_y + BULLET_Y) < (w_ye - w_h)));
      w_collide = r_ise && w_in_x && w_in_y;
      w_exit    = r_ise && !w_collide && (w_xn > (MAP_X - BULLET_X));
   end

   // Slot state: spawn loads the muzzle position, flight steps x and clears on hit/exit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x   <= '0;
         r_y   <= '0;
         r_ise <= 1'b0;
      end else if (i_spawn) begin
         r_x   <= i_spawn_x;
         r_y   <= i_spawn_y;
         r_ise <= 1'b1;
      end else if (r_ise) begin
         r_x <= w_xn[10:0];
         if (w_collide || w_exit) begin
            r_ise <= 1'b0;
         end
      end
   end

   assign o_x       = r_x;
   assign o_y       = r_y;
   assign o_ise     = r_ise;
   assign o_collide = w_collide;

endmodule

// File: rtl/player_bullet_pool.sv
// rtl/player_bullet_pool.sv - player bullet pool: slot allocation, fire cooldown and hit/block pulses
module player_bullet_pool
   import game_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    attack,
   input  logic                    defend,
   input  logic signed [10:0]      xPlayer,
   input  logic signed [9:0]       yPlayer,
   input  logic signed [10:0]      xEnemy,
   input  logic signed [9:0]       yEnemy,
   input  logic                    enemyQ,
   input  logic                    enemyDef,
   output logic signed [10:0]      x [N_PBULLET],
   output logic signed [9:0]       y [N_PBULLET],
   output logic [N_PBULLET-1:0]    isE,
   output logic                    isHit,
   output logic [HIT_W-1:0]        hitCnt,
   output logic                    blocked
);

   logic [CD_W-1:0]      r_cooldown;
   logic                 r_is_hit;
   logic [HIT_W-1:0]     r_hit_cnt;
   logic                 r_blocked;

   logic                 w_fire;
   logic                 w_found;
   logic [N_PBULLET-1:0] w_spawn;
   logic [N_PBULLET-1:0] w_collide;
   logic [N_PBULLET-1:0] w_hit_vec;
   logic [N_PBULLET-1:0] w_block_vec;
   logic [HIT_W-1:0]     w_hit_cnt;
   logic [10:0]          w_spawn_x;

   assign w_fire    = attack && !defend && (r_cooldown == '0) && !(&isE);
   assign w_spawn_x = 11'(sx11(xPlayer) + PLAYER_X + BULLET_X);

   // Lowest-index idle slot per registered isE, so a slot freed this edge waits one edge
   always_comb begin
      w_spawn = '0;
      w_found = 1'b0;
      for (int i = 0; i < N_PBULLET; i++) begin
         if (!isE[i] && !w_found) begin
            w_spawn[i] = w_fire;
            w_found    = 1'b1;
         end
      end
   end

   // Split collisions into damaging hits and shield blocks, and count the hits
   always_comb begin
      w_hit_vec   = w_collide & {N_PBULLET{~enemyDef}};
      w_block_vec = w_collide & {N_PBULLET{enemyDef}};
      w_hit_cnt   = '0;
      for (int i = 0; i < N_PBULLET; i++) begin
         w_hit_cnt = w_hit_cnt + HIT_W'(w_hit_vec[i]);
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_PBULLET; g++) begin : g_slot
         player_bullet_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_spawn   (w_spawn[g]),
            .i_spawn_x (w_spawn_x),
            .i_spawn_y (yPlayer),
            .i_x_enemy (xEnemy),
            .i_y_enemy (yEnemy),
            .i_enemy_q (enemyQ),
            .o_x       (x[g]),
            .o_y       (y[g]),
            .o_ise     (isE[g]),
            .o_collide (w_collide[g])
         );
      end
   endgenerate

   // Fire cooldown: reload on an accepted shot, otherwise count down to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cooldown <= '0;
      end else if (w_fire) begin
         r_cooldown <= CD_W'(FIRE_COOLDOWN - 1);
      end else if (r_cooldown != '0) begin
         r_cooldown <= r_cooldown - 1'b1;
      end
   end

   // Hit/block pulses registered on the same edge that clears the slots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_is_hit  <= 1'b0;
         r_hit_cnt <= '0;
         r_blocked <= 1'b0;
      end else begin
         r_is_hit  <= |w_hit_vec;
         r_hit_cnt <= w_hit_cnt;
         r_blocked <= |w_block_vec;
      end
   end

   assign isHit   = r_is_hit;
   assign hitCnt  = r_hit_cnt;
   assign blocked = r_blocked;

endmodule

// File: tb/tb_player_bullet_pool.sv
// tb/tb_player_bullet_pool.sv - self-checking bench for player_bullet_pool
module tb_player_bullet_pool;

   localparam int NB = 4;

   logic               clk;
   logic               rst;
   logic               attack;
   logic               defend;
   logic signed [10:0] xPlayer;
   logic signed [9:0]  yPlayer;
   logic signed [10:0] xEnemy;
   logic signed [9:0]  yEnemy;
   logic               enemyQ;
   logic               enemyDef;
   logic signed [10:0] x [NB];
   logic signed [9:0]  y [NB];
   logic [NB-1:0]      isE;
   logic               isHit;
   logic [2:0]         hitCnt;
   logic               blocked;

   int n_checks;
   int n_fail;

   // Reference model state: bullets as plain integers
   int mx [NB];
   int my [NB];
   bit me [NB];
   int mcd;
   int m_hit_cnt;
   bit m_blocked;

   player_bullet_pool dut (
      .clk      (clk),
      .rst      (rst),
      .attack   (attack),
      .defend   (defend),
      .xPlayer  (xPlayer),
      .yPlayer  (yPlayer),
      .xEnemy   (xEnemy),
      .yEnemy   (yEnemy),
      .enemyQ   (enemyQ),
      .enemyDef (enemyDef),
      .x        (x),
      .y        (y),
      .isE      (isE),
      .isHit    (isHit),
      .hitCnt   (hitCnt),
      .blocked  (blocked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mx[i] = 0;
         my[i] = 0;
         me[i] = 1'b0;
      end
      mcd       = 0;
      m_hit_cnt = 0;
      m_blocked = 1'b0;
   endtask

   // One game tick from the rules: move every bullet, resolve enemy/edge, then fire
   task automatic model_step();
      bit old_e [NB];
      int h, xe, ye, xn, hits, blks, slot;
      bit col, fire;
      old_e = me;
      h     = enemyQ ? 16 : 32;
      xe    = int'(xEnemy);
      ye    = int'(yEnemy);
      hits  = 0;
      blks  = 0;
      for (int i = 0; i < NB; i++) begin
         if (old_e[i]) begin
            xn  = mx[i] + 8;
            col = (xn + 4 > xe - 16) && !((my[i] - 4 > ye + h) || (my[i] + 4 < ye - h));
            if (col) begin
               me[i] = 1'b0;
               if (enemyDef) blks++;
               else hits++;
            end else if (xn > 320 - 4) begin
               me[i] = 1'b0;
            end
            mx[i] = xn;
         end
      end
      slot = -1;
      for (int i = 0; i < NB; i++) begin
         if (!old_e[i] && slot < 0) slot = i;
      end
      fire = attack && !defend && (mcd == 0) && (slot >= 0);
      if (fire) begin
         me[slot] = 1'b1;
         mx[slot] = int'(xPlayer) + 16 + 4;
         my[slot] = int'(yPlayer);
         mcd      = 7;
      end else if (mcd > 0) begin
         mcd--;
      end
      m_hit_cnt = hits;
      m_blocked = (blks > 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic set_scene(input int xp, input int yp, input int xe, input int ye,
                            input bit q, input bit d);
      xPlayer  = 11'(xp);
      yPlayer  = 10'(yp);
      xEnemy   = 11'(xe);
      yEnemy   = 10'(ye);
      enemyQ   = q;
      enemyDef = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      n_checks++;
      if (isE !== 4'b0000 || isHit !== 1'b0 || hitCnt !== 3'd0 || blocked !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: isE=%b isHit=%b hitCnt=%0d blocked=%b required 0000/0/0/0",
                  isE, isHit, hitCnt, blocked);
      end
      for (int i = 0; i < NB; i++) begin
         n_checks++;
         if (x[i] !== 11'sd0 || y[i] !== 10'sd0) begin
            n_fail++;
            $display("FAIL reset_pos[%0d]: x=%0d y=%0d required 0/0", i, x[i], y[i]);
         end
      end
      do_reset();
   endtask

   task automatic test_spawn();
      do_reset();
      set_scene(-100, 0, 300, 0, 1'b0, 1'b0);
      attack = 1'b1;
      tick();
      attack = 1'b0;
      n_checks++;
      if (isE !== 4'b0001 || x[0] !== -11'sd80 || y[0] !== 10'sd0) begin
         n_fail++;
         $display("FAIL spawn: isE=%b x0=%0d y0=%0d required 0001/-80/0", isE, x[0], y[0]);
      end
      tick();
      n_checks++;
      if (x[0] !== -11'sd72) begin
         n_fail++;
         $display("FAIL spawn_step: x0=%0d required -72", x[0]);
      end
   endtask

   task automatic test_hit();
      do_reset();
      set_scene(-100, 0, 0, 0, 1'b0, 1'b0);
      attack = 1'b1;
      tick();
      attack = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         n_checks++;
         if (isHit !== 1'b0 || isE[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_flight edge %0d: isHit=%b isE0=%b required 0/1", k, isHit, isE[0]);
         end
      end
      tick();
      n_checks++;
      if (x[0] !== -11'sd16 || isHit !== 1'b1 || hitCnt !== 3'd1 || isE[0] !== 1'b0 || blocked !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_edge: x0=%0d isHit=%b hitCnt=%0d isE0=%b blocked=%b required -16/1/1/0/0",
                  x[0], isHit, hitCnt, isE[0], blocked);
      end
      tick();
      n_checks++;
      if (isHit !== 1'b0 || hitCnt !== 3'd0) begin
         n_fail++;
         $display("FAIL hit_pulse_len: isHit=%b hitCnt=%0d required 0/0", isHit, hitCnt);
      end
   endtask

   task automatic test_miss_despawn();
      int steps;
      bit seen_hit;
      do_reset();
      set_scene(-100, 24, 0, 0, 1'b1, 1'b0);
      attack = 1'b1;
      tick();
      attack = 1'b0;
      steps    = 0;
      seen_hit = 1'b0;
      while (steps < 60) begin
         tick();
         steps++;
         if (isHit !== 1'b0) seen_hit = 1'b1;
         if (isE[0] !== 1'b1) break;
      end
      n_checks++;
      if (seen_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_no_hit: isHit seen=%b required 0", seen_hit);
      end
      n_checks++;
      if (steps != 50 || x[0] !== 11'sd320) begin
         n_fail++;
         $display("FAIL miss_despawn: edges=%0d x0=%0d required 50/320", steps, x[0]);
      end
   endtask

   task automatic test_full_pool();
      int ev_edge[$];
      int ev_slot[$];
      int exp_edge [5];
      int exp_slot [5];
      logic [NB-1:0] prev;
      logic [NB-1:0] rising;
      bit hit73;
      // slot0 launched at -300 meets the enemy at 300 once xn > 280: xn=284 on edge 73
      exp_edge = '{0, 8, 16, 24, 74};
      exp_slot = '{0, 1, 2, 3, 0};
      do_reset();
      set_scene(-320, 0, 300, 0, 1'b0, 1'b0);
      attack = 1'b1;
      prev   = '0;
      hit73  = 1'b0;
      for (int e = 0; e <= 76; e++) begin
         tick();
         rising = isE & ~prev;
         for (int s = 0; s < NB; s++) begin
            if (rising[s]) begin
               ev_edge.push_back(e);
               ev_slot.push_back(s);
            end
         end
         if (e == 73) hit73 = isHit;
         prev = isE;
      end
      attack = 1'b0;
      n_checks++;
      if (ev_edge.size() != 5) begin
         n_fail++;
         $display("FAIL pool_events: count=%0d required 5", ev_edge.size());
      end
      for (int i = 0; i < 5; i++) begin
         if (i < ev_edge.size()) begin
            n_checks++;
            if (ev_edge[i] != exp_edge[i] || ev_slot[i] != exp_slot[i]) begin
               n_fail++;
               $display("FAIL pool_fire[%0d]: edge=%0d slot=%0d required edge=%0d slot=%0d",
                        i, ev_edge[i], ev_slot[i], exp_edge[i], exp_slot[i]);
            end
         end
      end
      n_checks++;
      if (hit73 !== 1'b1) begin
         n_fail++;
         $display("FAIL pool_free_hit: isHit at edge 73=%b required 1", hit73);
      end
   endtask

   task automatic test_block_defend();
      bit fired;
      do_reset();
      set_scene(-100, 0, 0, 0, 1'b0, 1'b1);
      attack = 1'b1;
      tick();
      attack = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      n_checks++;
      if (blocked !== 1'b1 || isHit !== 1'b0 || hitCnt !== 3'd0 || isE[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL block: blocked=%b isHit=%b hitCnt=%0d isE0=%b required 1/0/0/0",
                  blocked, isHit, hitCnt, isE[0]);
      end
      do_reset();
      set_scene(-100, 0, 300, 0, 1'b0, 1'b0);
      attack = 1'b1;
      defend = 1'b1;
      fired  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (isE !== 4'b0000) fired = 1'b1;
      end
      attack = 1'b0;
      defend = 1'b0;
      n_checks++;
      if (fired !== 1'b0) begin
         n_fail++;
         $display("FAIL defend_inhibit: fired=%b required 0", fired);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_scene(-100, 0, 300, 0, 1'b0, 1'b0);
      attack = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      n_checks++;
      if (isE !== 4'b0011) begin
         n_fail++;
         $display("FAIL async_setup: isE=%b required 0011", isE);
      end
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (isE !== 4'b0000 || x[0] !== 11'sd0 || x[1] !== 11'sd0) begin
         n_fail++;
         $display("FAIL async_clear: isE=%b x0=%0d x1=%0d required 0000/0/0", isE, x[0], x[1]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      attack = 1'b0;
      n_checks++;
      if (isE !== 4'b0001 || x[0] !== -11'sd80) begin
         n_fail++;
         $display("FAIL async_refire: isE=%b x0=%0d required 0001/-80", isE, x[0]);
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] mev;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         attack   = ($urandom_range(0, 9) < 7);
         defend   = ($urandom_range(0, 9) < 2);
         xPlayer  = 11'(int'($urandom_range(0, 700)) - 400);
         yPlayer  = 10'(int'($urandom_range(0, 120)) - 60);
         xEnemy   = 11'(int'($urandom_range(0, 630)) - 300);
         yEnemy   = 10'(int'($urandom_range(0, 80)) - 40);
         enemyQ   = 1'($urandom_range(0, 1));
         enemyDef = ($urandom_range(0, 3) == 0);
         tick();
         for (int i = 0; i < NB; i++) mev[i] = me[i];
         n_checks++;
         if (isE !== mev) begin
            n_fail++;
            $display("FAIL rand_isE cyc %0d: got %b required %b", c, isE, mev);
         end
         for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (int'(x[i]) != mx[i] || int'(y[i]) != my[i]) begin
               n_fail++;
               $display("FAIL rand_pos cyc %0d slot %0d: x=%0d y=%0d required %0d/%0d",
                        c, i, x[i], y[i], mx[i], my[i]);
            end
         end
         n_checks++;
         if (isHit !== (m_hit_cnt > 0) || int'(hitCnt) != m_hit_cnt || blocked !== m_blocked) begin
            n_fail++;
            $display("FAIL rand_pulse cyc %0d: isHit=%b hitCnt=%0d blocked=%b required %b/%0d/%b",
                     c, isHit, hitCnt, blocked, (m_hit_cnt > 0), m_hit_cnt, m_blocked);
         end
      end
      attack = 1'b0;
      defend = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      attack   = 1'b0;
      defend   = 1'b0;
      set_scene(0, 0, 0, 0, 1'b0, 1'b0);
      model_reset();
      test_reset();
      test_spawn();
      test_hit();
      test_miss_despawn();
      test_full_pool();
      test_block_defend();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
